// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC, one outstanding imem request at a time,
// feeding {pc+4, instruction} to IF/ID with stall and redirect handling.
module if_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic                     imem_rvalid_i,
    input  logic [DATA_W-1:0]        imem_rdata_i,
    output logic [ADDR_W+DATA_W-1:0] ifid_data_o,
    output logic                     ifid_write_o,
    output logic                     ifid_flush_o,
    output logic                     busy_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
    state_t state;
    logic [ADDR_W-1:0] pc, pc_next4;
    logic [DATA_W-1:0] buffer;
    logic deliver;
    assign pc_next4 = pc + ADDR_W'(4);
    // A fresh response or the buffered one goes to IF/ID only when nothing blocks it
    assign deliver = !redirect_i && !stall_i && ((state == WAIT && imem_rvalid_i) || state == HOLD);
    assign ifid_write_o = deliver;
    assign ifid_data_o = deliver ? {pc_next4, state == HOLD ? buffer : imem_rdata_i} : '0;
    assign ifid_flush_o = redirect_i && rst_i;
    assign imem_req_o = state == REQ;
    assign imem_addr_o = state == REQ ? pc : '0;
    assign busy_o = state == WAIT || state == DROP;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            pc <= RESET_PC;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_i) pc <= redirect_pc_i;
                end
                REQ: begin
                    state <= redirect_i ? DROP : WAIT;
                    if (redirect_i) pc <= redirect_pc_i;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (redirect_i) begin
                            pc <= redirect_pc_i;
                            state <= REQ;
                        end else if (stall_i) begin
                            buffer <= imem_rdata_i;
                            state <= HOLD;
                        end else begin
                            pc <= pc_next4;
                            state <= REQ;
                        end
                    end else if (redirect_i) begin
                        pc <= redirect_pc_i;
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        buffer <= '0;
                        pc <= redirect_pc_i;
                        state <= REQ;
                    end else if (!stall_i) begin
                        pc <= pc_next4;
                        state <= REQ;
                    end
                end
                DROP: begin
                    // The stale response must still be absorbed before a new request
                    if (redirect_i) pc <= redirect_pc_i;
                    if (imem_rvalid_i) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plus random stimulus against a transaction-level fetch model.
module tb_if_fetch_unit;
    logic clk = 0, rst = 0, stall = 0, redir = 0, rvalid = 0;
    logic [31:0] rpc = 0, rdata = 0;
    logic req, write, flush, busy;
    logic [31:0] addr;
    logic [63:0] data;
    int checks = 0, errors = 0;
    // reference model: what has been promised to the pipeline, not how the RTL encodes it
    bit m_run, m_issue, m_out, m_drop, m_hold;
    logic [31:0] m_pc, m_buf;
    // memory environment
    bit pend;
    int cnt, lat = 1;
    logic [31:0] maddr;

    if_fetch_unit dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .ifid_data_o(data), .ifid_write_o(write), .ifid_flush_o(flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a * 3 + 32'h2008_0005;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_issue = 0; m_out = 0; m_drop = 0; m_hold = 0;
        m_pc = 0; m_buf = 0; pend = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0; redir = 1; stall = 0; rvalid = 0;
        #1;
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_addr", {32'd0, addr}, 64'd0);
        chk("rst_write", {63'd0, write}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1; redir = 0;
    endtask

    task automatic step(bit s, bit r, logic [31:0] t, bit inj = 0);
        bit dlv, rv;
        logic [31:0] instr, rd;
        @(negedge clk);
        stall = s; redir = r; rpc = t;
        if (pend) cnt--;
        if (pend && cnt == 0) begin
            rvalid = 1; rdata = mem_word(maddr); pend = 0;
        end else begin
            rvalid = inj; rdata = $urandom;
        end
        rv = rvalid; rd = rdata;
        #1;
        dlv = !r && !s && ((m_out && !m_drop && rv) || m_hold);
        instr = m_hold ? m_buf : rd;
        chk("req", {63'd0, req}, {63'd0, m_issue});
        chk("addr", {32'd0, addr}, {32'd0, m_issue ? m_pc : 32'd0});
        chk("busy", {63'd0, busy}, {63'd0, m_out});
        chk("flush", {63'd0, flush}, {63'd0, r});
        chk("write", {63'd0, write}, {63'd0, dlv});
        chk("data", data, dlv ? {m_pc + 32'd4, instr} : 64'd0);
        if (req) begin
            pend = 1; cnt = lat; maddr = addr;
        end
        if (!m_run) begin
            m_run = 1; m_issue = 1;
            if (r) m_pc = t;
        end else if (m_issue) begin
            m_issue = 0; m_out = 1; m_drop = r;
            if (r) m_pc = t;
        end else if (m_out) begin
            if (rv) begin
                m_out = 0;
                if (m_drop || r) begin
                    if (r) m_pc = t;
                    m_issue = 1;
                end else if (s) begin
                    m_hold = 1; m_buf = rd;
                end else begin
                    m_pc += 4; m_issue = 1;
                end
                m_drop = 0;
            end else if (r) begin
                m_pc = t; m_drop = 1;
            end
        end else if (m_hold) begin
            if (r) begin
                m_hold = 0; m_pc = t; m_issue = 1;
            end else if (!s) begin
                m_hold = 0; m_pc += 4; m_issue = 1;
            end
        end
    endtask

    task automatic to_req();
        for (int i = 0; i < 12 && !m_issue; i++) step(0, 0, 0);
        chk("to_req_reached", {63'd0, m_issue}, 64'd1);
    endtask

    initial begin
        model_reset();
        do_reset();
        lat = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("tp1_addr0", {32'd0, addr}, 64'd0);
        step(0, 0, 0);
        chk("tp1_data", data, {32'h4, 32'h2008_0005});
        step(0, 0, 0);
        chk("tp1_addr4", {32'd0, addr}, 64'h4);
        lat = 3;
        repeat (8) step(0, 0, 0);
        lat = 1;
        to_req();
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("stall_release_write", {63'd0, write}, 64'd1);
        lat = 2;
        to_req();
        step(0, 1, 32'h100);
        repeat (4) step(0, 0, 0);
        lat = 1;
        to_req();
        step(0, 0, 0);
        step(0, 1, 32'h200);
        step(0, 0, 0);
        chk("redir_wait_addr", {32'd0, addr}, 64'h200);
        to_req();
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 1, 32'h300);
        step(0, 0, 0);
        chk("hold_redir_addr", {32'd0, addr}, 64'h300);
        lat = 4;
        to_req();
        step(0, 0, 0);
        step(0, 0, 0);
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("restart_addr", {32'd0, addr}, 64'h0);
        lat = 1;
        to_req();
        step(0, 1, 32'hFFFF_FFFC);
        repeat (6) step(0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(1, 4);
            if (i == 300) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
